// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and stage types for the mult_arb multiplier slice.
package mult_pkg;

   localparam int OPW   = 3;  // operand width (two's complement)
   localparam int PRODW = 6;  // exact product width for OPW x OPW signed

   typedef logic signed [OPW-1:0]   operand_t;
   typedef logic signed [PRODW-1:0] product_t;

   // Operand stage: the captured operand pair and its valid flag.
   typedef struct packed {
      logic     v;
      operand_t a;
      operand_t b;
   } s1_t;

   // Result stage: the product and its valid flag.
   typedef struct packed {
      logic     v;
      product_t y;
   } s2_t;

endpackage

// File: rtl/mult3s.sv
// mult3s: combinational 3x3 signed Baugh-Wooley multiplier.
// Partial products that involve exactly one sign bit enter inverted, and the
// constant 2^3 + 2^5 restores the two's-complement weighting, so the whole
// product reduces to one unsigned sum taken modulo 2^6.
module mult3s
   import mult_pkg::*;
(
   input  operand_t a,
   input  operand_t b,
   output product_t y
);

   logic [PRODW-1:0] acc;

   assign acc = 6'b101000
              + {5'b0, a[0] & b[0]}
              + {4'b0, a[1] & b[0], 1'b0}
              + {4'b0, a[0] & b[1], 1'b0}
              + {3'b0, a[1] & b[1], 2'b0}
              + {3'b0, ~(a[2] & b[0]), 2'b0}
              + {3'b0, ~(a[0] & b[2]), 2'b0}
              + {2'b0, ~(a[2] & b[1]), 3'b0}
              + {2'b0, ~(a[1] & b[2]), 3'b0}
              + {1'b0, a[2] & b[2], 4'b0};

   assign y = product_t'(acc);

endmodule

// File: rtl/mult_arb.sv
// mult_arb: NREQ requesters share one 3x3 signed multiplier behind a
// two-stage valid/ready pipeline (S1 operands, S2 product).
// Build option: define MULT_ARB_RR_EN for round-robin arbitration; without it
// the lowest-index valid requester always wins and no pointer exists.
module mult_arb
   import mult_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ-1:0][OPW-1:0]  req_a,
   input  logic [NREQ-1:0][OPW-1:0]  req_b,
   output logic [NREQ-1:0]           req_ready,
   output logic                      res_valid,
   output logic [PRODW-1:0]          res_y,
   output logic [IDW-1:0]            res_id,
   input  logic                      res_ready
);

   s1_t            s1_q;
   s2_t            s2_q;
   logic [IDW-1:0] s1_id_q;
   logic [IDW-1:0] s2_id_q;
   product_t       prod;

   logic           advance;
   logic           s1_load;
   logic           found;
   logic           transfer;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] idx;
   logic [IDW:0]   idx_sum;
   logic [NREQ-1:0] gnt_vec;

`ifdef MULT_ARB_RR_EN
   logic [IDW-1:0] ptr_q;
`endif

   // S2 moves when it is empty or being drained; S1 moves when it is empty or S2 takes it.
   assign advance = !s2_q.v || res_ready;
   assign s1_load = !s1_q.v || advance;

   // Pick the first valid requester, scanning upward from the pointer (or from 0).
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      found   = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      idx_sum = '0;
      gnt_vec = '0;
      for (int k = 0; k < NREQ; k++) begin
         // NOTE: blocking assignments here, so later iterations see earlier results.
`ifdef MULT_ARB_RR_EN
         idx_sum = {1'b0, ptr_q} + (IDW+1)'(k);
`else
         idx_sum = (IDW+1)'(k);
`endif
         if (idx_sum >= (IDW+1)'(NREQ)) idx_sum = idx_sum - (IDW+1)'(NREQ);
         idx = idx_sum[IDW-1:0];
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            gnt_id = idx;
         end
      end
      // Grant only when S1 can actually take the operands; nothing during reset.
      if (found && s1_load && rst_n) gnt_vec[gnt_id] = 1'b1;
   end

   assign req_ready = gnt_vec;
   assign transfer  = |gnt_vec;

   // S1: capture the granted requester's operands whenever the stage may load.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: data fields are reset too, so nothing stale survives a mid-flight reset.
      if (!rst_n) begin
         s1_q    <= '0;
         s1_id_q <= '0;
      end else if (s1_load) begin
         // NOTE: non-blocking for all state, so every register sees pre-edge values.
         s1_q.v  <= transfer;
         s1_q.a  <= req_a[gnt_id];
         s1_q.b  <= req_b[gnt_id];
         s1_id_q <= gnt_id;
      end
   end

   mult3s u_mult (
      .a (s1_q.a),
      .b (s1_q.b),
      .y (prod)
   );

   // S2: register the product; holds still while the result is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_q    <= '0;
         s2_id_q <= '0;
      end else if (advance) begin
         s2_q.v  <= s1_q.v;
         s2_q.y  <= prod;
         s2_id_q <= s1_id_q;
      end
   end

`ifdef MULT_ARB_RR_EN
   // Round-robin pointer: one past the last granted requester, moved only on a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (transfer) begin
         ptr_q <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      end
   end
`endif

   assign res_valid = s2_q.v;
   assign res_y     = s2_q.y;
   assign res_id    = s2_id_q;

endmodule
